// File: rtl/cmd_sequencer.sv
// -----------------------------------------------------------------------------
// cmd_sequencer
//   Command-stream scheduler between the host input FIFO and the device
//   multiplexer. Words are fetched one at a time. Timing opcodes are executed
//   locally: WAIT (relative delay), SYNC (absolute sync to the run-elapsed
//   counter) and HALT. DEV words are dispatched to the multiplexer one at a
//   time, using an en/idle handshake with a guard window and a timeout.
//
// Parameters
//   DEV_TIMEOUT   max consecutive DEV_WAIT cycles with mux_idle_i low
//   GUARD_CYCLES  cycles after a dispatch during which mux_idle_i is ignored (1-15)
//
// Ports
//   fpga_clk_i    sole clock, rising edge
//   reset_n_i     synchronous active-low reset
//   start_i       pulse: start a run from STOPPED or ERROR
//   abort_i       pulse: terminate the run from any state
//   fifo_empty_i  input FIFO empty flag
//   fifo_data_i   FIFO read data, valid the cycle after fifo_rd_o
//   fifo_rd_o     FIFO read enable, one pulse per word
//   mux_data_o    device command {device[7:0], payload[19:0]}
//   mux_en_o      one-cycle dispatch strobe
//   mux_idle_i    multiplexer ready for a command
//   busy_o        high outside STOPPED and ERROR
//   done_o        one-cycle pulse when HALT executes
//   error_o       high while in ERROR
//   error_code_o  01 illegal opcode, 10 device timeout, 00 otherwise
//   cmd_count_o   completed commands this run (saturating)
//   elapsed_o     cycles since start (wrapping)
//   state_o       current state encoding
// -----------------------------------------------------------------------------
module cmd_sequencer #(
  parameter int unsigned DEV_TIMEOUT  = 32'd1048576,
  parameter int unsigned GUARD_CYCLES = 32'd1
) (
  input  logic        fpga_clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        fifo_empty_i,
  input  logic [31:0] fifo_data_i,
  output logic        fifo_rd_o,
  output logic [27:0] mux_data_o,
  output logic        mux_en_o,
  input  logic        mux_idle_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  error_code_o,
  output logic [15:0] cmd_count_o,
  output logic [31:0] elapsed_o,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    ST_STOPPED  = 4'd0,
    ST_READY    = 4'd1,
    ST_FETCH    = 4'd2,
    ST_LATCH    = 4'd3,
    ST_DECODE   = 4'd4,
    ST_DISPATCH = 4'd5,
    ST_GUARD    = 4'd6,
    ST_DEV_WAIT = 4'd7,
    ST_DELAY    = 4'd8,
    ST_SYNC     = 4'd9,
    ST_ERROR    = 4'd10
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_DEV  = 4'h1;
  localparam logic [3:0] OP_WAIT = 4'h2;
  localparam logic [3:0] OP_SYNC = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Timeout counter counts 0 .. DEV_TIMEOUT-1 while idle stays low.
  localparam int unsigned TW       = (DEV_TIMEOUT > 32'd1) ? $clog2(DEV_TIMEOUT) : 32'd1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DEV_TIMEOUT - 32'd1);
  localparam logic [3:0]  GUARD_LD = 4'(GUARD_CYCLES);

  state_e        state_q, state_d;
  logic [31:0]   cmd_q, cmd_d;
  logic [27:0]   delay_q, delay_d;
  logic [3:0]    guard_q, guard_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   elapsed_q, elapsed_d;
  logic [15:0]   cmd_count_q, cmd_count_d;
  logic          fifo_rd_q, fifo_rd_d;
  logic          mux_en_q, mux_en_d;
  logic [27:0]   mux_data_q, mux_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    error_code_q, error_code_d;

  logic [3:0]    op_s;
  logic          sync_hit_s;
  logic          start_s;
  logic          count_evt_s;

  assign op_s       = cmd_q[31:28];
  // SYNC target is in units of 16 cycles.
  assign sync_hit_s = (elapsed_q >= {cmd_q[27:0], 4'b0000});

  // State register
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort has priority over every other input
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_STOPPED;
    end else begin
      case (state_q)
        ST_STOPPED, ST_ERROR: begin
          if (start_i) state_d = ST_READY;
          else         state_d = state_q;
        end
        ST_READY: begin
          if (!fifo_empty_i) state_d = ST_FETCH;
          else               state_d = ST_READY;
        end
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: state_d = ST_DECODE;
        ST_DECODE: begin
          case (op_s)
            OP_NOP: state_d = ST_READY;
            OP_DEV: begin
              if (mux_idle_i) state_d = ST_DISPATCH;
              else            state_d = ST_DECODE;
            end
            OP_WAIT: begin
              if (cmd_q[27:0] == 28'd0) state_d = ST_READY;
              else                      state_d = ST_DELAY;
            end
            OP_SYNC: state_d = ST_SYNC;
            OP_HALT: state_d = ST_STOPPED;
            default: state_d = ST_ERROR;
          endcase
        end
        ST_DISPATCH: state_d = ST_GUARD;
        ST_GUARD: begin
          if (guard_q <= 4'd1) state_d = ST_DEV_WAIT;
          else                 state_d = ST_GUARD;
        end
        ST_DEV_WAIT: begin
          if (mux_idle_i)             state_d = ST_READY;
          else if (tmo_q >= TMO_LAST) state_d = ST_ERROR;
          else                        state_d = ST_DEV_WAIT;
        end
        ST_DELAY: begin
          if (delay_q <= 28'd1) state_d = ST_READY;
          else                  state_d = ST_DELAY;
        end
        ST_SYNC: begin
          if (sync_hit_s) state_d = ST_READY;
          else            state_d = ST_SYNC;
        end
        default: state_d = ST_STOPPED;
      endcase
    end
  end

  // Output next-values, derived from the upcoming state so outputs are registered
  always_comb begin
    fifo_rd_d = (state_d == ST_FETCH);
    mux_en_d  = (state_d == ST_DISPATCH);
    busy_d    = !((state_d == ST_STOPPED) || (state_d == ST_ERROR));
    error_d   = (state_d == ST_ERROR);
    done_d    = (state_q == ST_DECODE) && (op_s == OP_HALT) && !abort_i;
    if (mux_en_d) begin
      mux_data_d = cmd_q[27:0];
    end else begin
      mux_data_d = mux_data_q;
    end
    if (state_d == ST_ERROR) begin
      if (state_q == ST_ERROR)         error_code_d = error_code_q;
      else if (state_q == ST_DEV_WAIT) error_code_d = ERR_TIMEOUT;
      else                             error_code_d = ERR_ILLEGAL;
    end else begin
      error_code_d = ERR_NONE;
    end
  end

  // Datapath next-values: command word, delay/guard/timeout counters, run counters
  always_comb begin
    start_s     = ((state_q == ST_STOPPED) || (state_q == ST_ERROR)) && (state_d == ST_READY);
    count_evt_s = ((state_d == ST_READY) &&
                   ((state_q == ST_DECODE) || (state_q == ST_DEV_WAIT) ||
                    (state_q == ST_DELAY)  || (state_q == ST_SYNC))) || done_d;

    if (state_q == ST_LATCH) cmd_d = fifo_data_i;
    else                     cmd_d = cmd_q;

    if ((state_q == ST_DECODE) && (state_d == ST_DELAY)) delay_d = cmd_q[27:0];
    else if (state_q == ST_DELAY)                        delay_d = delay_q - 28'd1;
    else                                                 delay_d = delay_q;

    if (state_d == ST_DISPATCH)   guard_d = GUARD_LD;
    else if (state_q == ST_GUARD) guard_d = guard_q - 4'd1;
    else                          guard_d = guard_q;

    // Restarts at zero on every entry into DEV_WAIT.
    if (state_q == ST_DEV_WAIT) tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
    else                        tmo_d = {TW{1'b0}};

    // The abort cycle does not count, so elapsed freezes at the abort point.
    if (start_s)                 elapsed_d = 32'd0;
    else if (busy_q && !abort_i) elapsed_d = elapsed_q + 32'd1;
    else                         elapsed_d = elapsed_q;

    if (start_s)                                      cmd_count_d = 16'd0;
    else if (count_evt_s && (cmd_count_q != 16'hFFFF)) cmd_count_d = cmd_count_q + 16'd1;
    else                                              cmd_count_d = cmd_count_q;
  end

  // Datapath and output registers
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      cmd_q        <= 32'd0;
      delay_q      <= 28'd0;
      guard_q      <= 4'd0;
      tmo_q        <= {TW{1'b0}};
      elapsed_q    <= 32'd0;
      cmd_count_q  <= 16'd0;
      fifo_rd_q    <= 1'b0;
      mux_en_q     <= 1'b0;
      mux_data_q   <= 28'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= 2'b00;
    end else begin
      cmd_q        <= cmd_d;
      delay_q      <= delay_d;
      guard_q      <= guard_d;
      tmo_q        <= tmo_d;
      elapsed_q    <= elapsed_d;
      cmd_count_q  <= cmd_count_d;
      fifo_rd_q    <= fifo_rd_d;
      mux_en_q     <= mux_en_d;
      mux_data_q   <= mux_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign fifo_rd_o    = fifo_rd_q;
  assign mux_en_o     = mux_en_q;
  assign mux_data_o   = mux_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign error_code_o = error_code_q;
  assign cmd_count_o  = cmd_count_q;
  assign elapsed_o    = elapsed_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cmd_sequencer
//   Directed self-checking bench for cmd_sequencer. A queue models the host
//   FIFO (data returned the cycle after fifo_rd_o). One task per scenario.
// -----------------------------------------------------------------------------
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = 32'd0;
  logic        mux_idle = 1'b1;
  logic        fifo_rd;
  logic [27:0] mux_data;
  logic        mux_en;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  error_code;
  logic [15:0] cmd_count;
  logic [31:0] elapsed;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [31:0] fq[$];

  always #5 clk = ~clk;

  cmd_sequencer #(.DEV_TIMEOUT(16), .GUARD_CYCLES(1)) dut (
    .fpga_clk_i  (clk),
    .reset_n_i   (reset_n),
    .start_i     (start),
    .abort_i     (abort),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_rd_o   (fifo_rd),
    .mux_data_o  (mux_data),
    .mux_en_o    (mux_en),
    .mux_idle_i  (mux_idle),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .error_code_o(error_code),
    .cmd_count_o (cmd_count),
    .elapsed_o   (elapsed),
    .state_o     (state)
  );

  // Advance one clock; sample on the falling edge and service the FIFO model.
  task automatic cyc();
    @(negedge clk);
    if (fifo_rd)  rd_cnt++;
    if (mux_en)   en_cnt++;
    if (done)     done_cnt++;
    if (fifo_rd && (fq.size() > 0)) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (state == s) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      cyc();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    push(32'h0000_0000);
    push(32'hF000_0000);
    repeat (3) cyc();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if ({fifo_rd, mux_en, busy, done, error} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b want=00000", {fifo_rd, mux_en, busy, done, error}); end
    checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL reset_code got=%b want=00", error_code); end
    checks++; if ({cmd_count, elapsed, mux_data} !== 76'd0) begin errors++; $display("FAIL reset_counters count=%0d elapsed=%0d data=%h want all 0", cmd_count, elapsed, mux_data); end
    reset_n = 1'b1;
    repeat (10) cyc();
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL no_start_read got=%0d want=0", rd_cnt); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL no_start_state got=%0d want=0", state); end
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_dev();
    int k_en;
    bit ok;
    en_cnt = 0; done_cnt = 0; mux_idle = 1'b1;
    push(32'h1031_2345);
    push(32'hF000_0000);
    do_start();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL dev_ready got=%0d want=1", state); end
    k_en = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (mux_en) begin
        k_en = k;
        break;
      end
    end
    checks++; if (k_en !== 4) begin errors++; $display("FAIL dev_latency got=%0d want=4", k_en); end
    checks++; if (mux_data !== 28'h031_2345) begin errors++; $display("FAIL dev_data got=%h want=0312345", mux_data); end
    mux_idle = 1'b0;
    repeat (10) cyc();
    mux_idle = 1'b1;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dev_done got=0 want=1"); end
    checks++; if (en_cnt !== 1) begin errors++; $display("FAIL dev_strobes got=%0d want=1", en_cnt); end
    checks++; if (cmd_count !== 16'd2) begin errors++; $display("FAIL dev_count got=%0d want=2", cmd_count); end
    cyc();
    checks++; if (done !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL dev_done_pulse done=%b cnt=%0d want 0/1", done, done_cnt); end
    checks++; if (mux_data !== 28'h031_2345) begin errors++; $display("FAIL dev_data_hold got=%h want=0312345", mux_data); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL dev_stopped got=%0d want=0", state); end
  endtask

  task automatic test_wait();
    int n;
    bit ok;
    push(32'h2000_0064);
    push(32'hF000_0000);
    do_start();
    wait_state(4'd8, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_enter got=0 want=1"); end
    n = 0;
    while ((state == 4'd8) && (n < 300)) begin
      n++;
      cyc();
    end
    checks++; if (n !== 100) begin errors++; $display("FAIL wait_len got=%0d want=100", n); end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL wait_exit got=%0d want=1", state); end
    wait_done(20, ok);
    checks++; if (!ok || cmd_count !== 16'd2) begin errors++; $display("FAIL wait_count done=%b got=%0d want=2", ok, cmd_count); end
    done_cnt = 0;
    push(32'h2000_0000);
    do_start();
    wait_state(4'd4, 10, ok);
    cyc();
    checks++; if (!ok || state !== 4'd1) begin errors++; $display("FAIL wait0_ready got=%0d want=1", state); end
    checks++; if (cmd_count !== 16'd1) begin errors++; $display("FAIL wait0_count got=%0d want=1", cmd_count); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++; if (state !== 4'd0 || done_cnt !== 0) begin errors++; $display("FAIL wait0_abort state=%0d done=%0d want 0/0", state, done_cnt); end
  endtask

  task automatic test_sync();
    int n;
    logic [31:0] last;
    bit ok;
    push(32'h2000_0020);
    push(32'h3000_0010);
    push(32'h3000_0000);
    push(32'hF000_0000);
    do_start();
    wait_state(4'd9, 60, ok);
    checks++; if (!ok || elapsed !== 32'd40) begin errors++; $display("FAIL sync_entry got=%0d want=40", elapsed); end
    n = 0; last = 32'd0;
    while ((state == 4'd9) && (n < 400)) begin
      last = elapsed;
      n++;
      cyc();
    end
    checks++; if (last !== 32'd256) begin errors++; $display("FAIL sync_exit_elapsed got=%0d want=256", last); end
    checks++; if (n !== 217) begin errors++; $display("FAIL sync_len got=%0d want=217", n); end
    wait_state(4'd9, 10, ok);
    n = 0;
    while ((state == 4'd9) && (n < 20)) begin
      n++;
      cyc();
    end
    checks++; if (!ok || n !== 1) begin errors++; $display("FAIL sync0_len got=%0d want=1", n); end
    wait_done(20, ok);
    checks++; if (!ok || cmd_count !== 16'd4) begin errors++; $display("FAIL sync_count done=%b got=%0d want=4", ok, cmd_count); end
  endtask

  task automatic test_illegal();
    bit ok;
    push(32'h5000_0000);
    do_start();
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (error) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok || error_code !== 2'b01) begin errors++; $display("FAIL illegal_code err=%b got=%b want=01", ok, error_code); end
    checks++; if (busy !== 1'b0 || state !== 4'd10) begin errors++; $display("FAIL illegal_state busy=%b state=%0d want 0/10", busy, state); end
    push(32'hF000_0000);
    do_start();
    checks++; if (state !== 4'd1 || error !== 1'b0 || error_code !== 2'b00) begin errors++; $display("FAIL restart state=%0d err=%b code=%b want 1/0/00", state, error, error_code); end
    checks++; if (elapsed !== 32'd0) begin errors++; $display("FAIL restart_elapsed got=%0d want=0", elapsed); end
    wait_done(20, ok);
    checks++; if (!ok || cmd_count !== 16'd1) begin errors++; $display("FAIL restart_count done=%b got=%0d want=1", ok, cmd_count); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    mux_idle = 1'b1;
    push(32'h1ABC_DEF0);
    do_start();
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (mux_en) begin
        ok = 1'b1;
        break;
      end
    end
    mux_idle = 1'b0;
    checks++; if (!ok || mux_data !== 28'hABC_DEF0) begin errors++; $display("FAIL tmo_dispatch got=%h want=abcdef0", mux_data); end
    wait_state(4'd7, 5, ok);
    n = 0;
    while ((state == 4'd7) && (n < 100)) begin
      n++;
      cyc();
    end
    checks++; if (!ok || n !== 16) begin errors++; $display("FAIL tmo_len got=%0d want=16", n); end
    checks++; if (state !== 4'd10 || error !== 1'b1 || error_code !== 2'b10) begin errors++; $display("FAIL tmo_code state=%0d err=%b code=%b want 10/1/10", state, error, error_code); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    mux_idle = 1'b1;
    checks++; if (state !== 4'd0 || error !== 1'b0) begin errors++; $display("FAIL tmo_abort state=%0d err=%b want 0/0", state, error); end
  endtask

  task automatic test_abort();
    bit ok;
    int rd_before;
    done_cnt = 0;
    push(32'h2000_03E8);
    push(32'hF000_0000);
    do_start();
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (elapsed == 32'd50) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    checks++; if (!ok || state !== 4'd8) begin errors++; $display("FAIL abort_delay state=%0d want=8", state); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++; if (state !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop state=%0d busy=%b want 0/0", state, busy); end
    checks++; if (elapsed !== 32'd50 || cmd_count !== 16'd0) begin errors++; $display("FAIL abort_hold elapsed=%0d count=%0d want 50/0", elapsed, cmd_count); end
    rd_before = rd_cnt;
    repeat (5) cyc();
    checks++; if (done_cnt !== 0 || rd_cnt !== rd_before || elapsed !== 32'd50) begin errors++; $display("FAIL abort_quiet done=%0d reads=%0d elapsed=%0d want 0/%0d/50", done_cnt, rd_cnt, elapsed, rd_before); end
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (state !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL start_abort state=%0d busy=%b want 0/0", state, busy); end
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    rd_cnt = 0;
    push(32'h0000_0000);
    push(32'h0ABC_DEF0);
    push(32'h0123_4567);
    push(32'hF000_0000);
    do_start();
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (done) begin
        n = k;
        break;
      end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL b2b_cycles got=%0d want=16", n); end
    checks++; if (cmd_count !== 16'd4 || rd_cnt !== 4) begin errors++; $display("FAIL b2b_count count=%0d reads=%0d want 4/4", cmd_count, rd_cnt); end
  endtask

  initial begin
    test_reset();
    test_dev();
    test_wait();
    test_sync();
    test_illegal();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command-stream scheduler between the host input FIFO (32-bit words) and the device multiplexer (28-bit device command, en/idle handshake). It fetches words, executes timing opcodes locally (relative delay, absolute sync to a run-elapsed counter, halt), and dispatches device opcodes to the multiplexer one at a time. The host sees run/done/error status and progress counters.

## Interface
- DEV_TIMEOUT, 1048576: max cycles DEV_WAIT may see mux_idle_i low before a timeout error.
- GUARD_CYCLES, 1: cycles after a dispatch during which mux_idle_i is ignored (range 1-15).
- fpga_clk_i  in  1  sole clock; all logic rising-edge.
- reset_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle pulse; starts a run from STOPPED or ERROR.
- abort_i  in  1  one-cycle pulse; terminates the run from any state.
- fifo_empty_i  in  1  input FIFO empty flag.
- fifo_data_i  in  32  FIFO read data; valid the cycle after fifo_rd_o.
- fifo_rd_o  out  1  FIFO read enable; one pulse per word.
- mux_data_o  out  28  device command: [27:20] device, [19:0] payload.
- mux_en_o  out  1  one-cycle dispatch strobe.
- mux_idle_i  in  1  multiplexer ready for a command.
- busy_o  out  1  high in every state except STOPPED and ERROR.
- done_o  out  1  one-cycle pulse when HALT executes.
- error_o  out  1  high while in ERROR.
- error_code_o  out  2  01 illegal opcode, 10 device timeout; 00 otherwise.
- cmd_count_o  out  16  completed commands this run, saturating at 0xFFFF.
- elapsed_o  out  32  cycles since start, wraps at 2^32.
- state_o  out  4  current state encoding, for debug.

## Operation
- Opcode is word[31:28]:
  - 0x0 NOP.
  - 0x1 DEV: dispatch word[27:0].
  - 0x2 WAIT: delay N = word[27:0] cycles.
  - 0x3 SYNC: wait until elapsed_o >= {word[27:0],4'b0}, unsigned compare.
  - 0xF HALT.
  - All other opcodes are illegal.
- States and encoding: STOPPED(0), READY(1), FETCH(2), LATCH(3), DECODE(4), DISPATCH(5), GUARD(6), DEV_WAIT(7), DELAY(8), SYNC(9), ERROR(10).
- STOPPED/ERROR:
  - start_i: go to READY; clear elapsed, cmd_count, error_code.
  - start_i in any other state is ignored.
- READY: if fifo_empty_i=0, go to FETCH; else stay. An empty FIFO stalls the run; it does not end it.
- FETCH: fifo_rd_o=1; go to LATCH. FETCH is entered only when the FIFO is non-empty.
- LATCH: capture fifo_data_i into the command register; go to DECODE.
- DECODE:
  - NOP: go to READY.
  - DEV: go to DISPATCH when mux_idle_i=1; otherwise hold in DECODE (no timeout here).
  - WAIT: N=0 goes to READY; otherwise load the counter with N and go to DELAY.
  - SYNC: go to SYNC.
  - HALT: pulse done_o, go to STOPPED.
  - Illegal opcode: go to ERROR with code 01.
- DISPATCH: mux_en_o=1 for exactly one cycle, mux_data_o=word[27:0]; go to GUARD.
- GUARD: ignore mux_idle_i for GUARD_CYCLES cycles; go to DEV_WAIT.
- DEV_WAIT:
  - mux_idle_i=1: go to READY.
  - mux_idle_i=0 for DEV_TIMEOUT consecutive cycles: go to ERROR with code 10.
- DELAY: decrement each cycle; leave for READY on the cycle the counter reads 1. DELAY therefore lasts exactly N cycles.
- SYNC: go to READY when the condition holds. If it already holds on entry, SYNC lasts 1 cycle.
- cmd_count increments on each transition into READY from DECODE, DEV_WAIT, DELAY or SYNC, and on HALT.
- elapsed increments every cycle while busy_o=1, including stalls; it holds in STOPPED and ERROR.
- mux_data_o holds its last dispatched value between dispatches.

## Timing
- Reset values: every output 0, state STOPPED, counters 0.
- Reset overrides all inputs.
- abort_i:
  - Next state is STOPPED; abort beats start_i in the same cycle.
  - A word popped in FETCH/LATCH is discarded.
  - mux_en_o is suppressed if abort_i coincides with DECODE→DISPATCH.
  - No done_o pulse; cmd_count and elapsed hold.
- Latency: READY with FIFO non-empty at cycle 0 gives fifo_rd_o at cycle 1 and DECODE at cycle 3. For DEV with mux_idle_i=1, mux_en_o is at cycle 4.
- Back-to-back commands: minimum 4 cycles per NOP (READY, FETCH, LATCH, DECODE).
- WAIT N costs 4+N cycles.
- error_o and error_code_o are registered and change with the entry into ERROR.

## Test plan
- After reset: all outputs 0, state_o=0. Words present but no start_i → fifo_rd_o never asserts.
- FIFO = {DEV 0x0312345, HALT}, mux_idle_i drops for 10 cycles after the strobe:
  - mux_en_o exactly once with mux_data_o=0x0312345, 4 cycles after READY sees non-empty.
  - done_o is pulsed; cmd_count_o=2.
- FIFO = {WAIT 100, HALT}: cycles from DELAY entry to READY = 100. {WAIT 0} goes straight to READY; cmd_count_o=1.
- SYNC with target 0x10 (elapsed 256), issued at elapsed 40: exits when elapsed_o=256. SYNC target 0 exits in 1 cycle.
- Error paths:
  - Illegal opcode 0x5 → error_o=1, code 01, busy_o=0.
  - DEV with mux_idle_i stuck low and DEV_TIMEOUT=16 → code 10 after 16 DEV_WAIT cycles.
  - start_i then clears the code and resumes.
- abort_i during DELAY(1000) at cycle 50 → STOPPED next cycle with no done_o. Simultaneous start_i+abort_i in STOPPED → remains STOPPED.
